// File: rtl/seq_divider32_pkg.sv
// Shared encodings and constants for the sequential 32-bit restoring divider.
package seq_divider32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int          DIV_CYCLES    = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_divider32_if.sv
// Start/busy/done handshake between ALU control (master) and the divider (slave).
interface seq_divider32_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (output start, in1, in2,
                  input  busy, done, divZero, quotient, remainder);
  modport slave  (input  start, in1, in2,
                  output busy, done, divZero, quotient, remainder);
endinterface

// File: rtl/seq_divider32_step.sv
// One restoring-division step: 33-bit trial subtract done as add of the inverted
// divisor with carry-in 1, so carry-out=1 means the trial did not borrow.
module div_step33 #(parameter int W = 32) (
  input  logic [W-1:0] rem,
  input  logic         msb,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_nxt,
  output logic         qbit,
  output logic         borrow
);
  logic [W:0]   partial;
  logic [W+1:0] sum;

  assign partial = {rem, msb};
  assign sum     = {1'b0, partial} + {1'b0, ~{1'b0, dvsr}} + {{(W+1){1'b0}}, 1'b1};
  assign qbit    = sum[W+1];
  assign borrow  = ~sum[W+1];
  assign rem_nxt = qbit ? sum[W-1:0] : partial[W-1:0];
endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results
// registered on entry to DONE and held until the next accepted start.
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider32_if.slave div
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] quot_out, rem_out;
  logic             divz_q;
  logic             accept;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit, borrow;

  div_step33 #(.W(WIDTH)) u_step (
    .rem     (rem_q),
    .msb     (quo_q[WIDTH-1]),
    .dvsr    (dvsr_q),
    .rem_nxt (rem_nxt),
    .qbit    (qbit),
    .borrow  (borrow)
  );

  assign accept = (state_q == ST_IDLE || state_q == ST_DONE) && div.start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!div.start)          state_d = ST_IDLE;
        else if (div.in2 == '0)  state_d = ST_DONE;
        else                     state_d = ST_RUN;
      end
      ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      quot_out <= '0;
      rem_out  <= '0;
      divz_q   <= 1'b0;
    end else if (accept) begin
      dvsr_q <= div.in2;
      divz_q <= 1'b0;
      if (div.in2 == '0) begin
        // Divide-by-zero finishes immediately with the all-ones convention.
        quot_out <= DIV_ZERO_QUOT[WIDTH-1:0];
        rem_out  <= div.in1;
        divz_q   <= 1'b1;
        cnt_q    <= '0;
      end else begin
        rem_q <= '0;
        quo_q <= div.in1;
        cnt_q <= CW'(DIV_CYCLES);
      end
    end else if (state_q == ST_RUN) begin
      rem_q <= rem_nxt;
      quo_q <= {quo_q[WIDTH-2:0], qbit};
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        quot_out <= {quo_q[WIDTH-2:0], qbit};
        rem_out  <= rem_nxt;
      end
    end
  end

  // The step's two status outputs are complements; catch a broken subtractor.
  a_step_consistent: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_RUN) |-> (qbit != borrow));

  assign div.busy      = (state_q == ST_RUN);
  assign div.done      = (state_q == ST_DONE);
  assign div.divZero   = divz_q;
  assign div.quotient  = quot_out;
  assign div.remainder = rem_out;
endmodule
